// File: rtl/memory_arbiter_2port.sv
// Two-requester round-robin sequencer for a single-port register memory.
// Commands are latched at grant, issued once, and acknowledged with a one-cycle pulse.
module memory_arbiter_2port #(
  parameter int AW     = 3,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // WAIT spans RD_LAT cycles; read data is captured in the last one
  localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

  state_t          state_reg, state_next;
  logic            cmd_id_reg;   // 0 = A, 1 = B
  logic            cmd_we_reg;
  logic [AW-1:0]   cmd_addr_reg;
  logic [DW-1:0]   cmd_din_reg;
  logic            prio_reg;     // 0 = A wins a tie, 1 = B wins a tie
  logic [2:0]      cnt_reg;
  logic [DW-1:0]   a_rdata_reg, b_rdata_reg;
  logic            grant_b;

  assign grant_b = b_req & (~a_req | prio_reg);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (a_req || b_req) state_next = ACCESS;
      ACCESS:  state_next = cmd_we_reg ? DONE : WAIT;
      WAIT:    if (cnt_reg == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command, priority, wait counter and read-data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_id_reg   <= 1'b0;
      cmd_we_reg   <= 1'b0;
      cmd_addr_reg <= '0;
      cmd_din_reg  <= '0;
      prio_reg     <= 1'b0;
      cnt_reg      <= '0;
      a_rdata_reg  <= '0;
      b_rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (a_req || b_req) begin
            cmd_id_reg   <= grant_b;
            cmd_we_reg   <= grant_b ? b_we   : a_we;
            cmd_addr_reg <= grant_b ? b_addr : a_addr;
            cmd_din_reg  <= grant_b ? b_din  : a_din;
          end
        end
        ACCESS: cnt_reg <= '0;
        WAIT: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == CNT_LAST) begin
            if (cmd_id_reg) b_rdata_reg <= mem_dout;
            else            a_rdata_reg <= mem_dout;
          end
        end
        DONE: prio_reg <= ~cmd_id_reg;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy   = (state_reg != IDLE);
    mem_we = (state_reg == ACCESS) && cmd_we_reg;
    a_ack  = (state_reg == DONE) && !cmd_id_reg;
    b_ack  = (state_reg == DONE) &&  cmd_id_reg;
  end

  // The memory port follows the latched command, so it holds between transactions
  assign mem_addr = cmd_addr_reg;
  assign mem_din  = cmd_din_reg;
  assign a_rdata  = a_rdata_reg;
  assign b_rdata  = b_rdata_reg;

endmodule

// File: tb/tb_memory_arbiter_2port.sv
// Scoreboard bench for memory_arbiter_2port with an 8x8 registered-read memory model.
// Expected acks are queued at issue time and retired by an independent monitor.
module tb_memory_arbiter_2port;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int RD_LAT = 1;

  logic          clk;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;

  memory_arbiter_2port #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one cycle of read latency
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  typedef struct {
    bit            id;
    bit            we;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit id, input bit we, input logic [DW-1:0] d);
    exp_t e;
    e.id = id;
    e.we = we;
    e.data = d;
    sbq.push_back(e);
  endtask

  // Monitor: retires one scoreboard entry per ack
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_count++;
    if (a_ack && b_ack) begin
      check("dual_ack", 32'(1), 32'(0));
    end else if (a_ack || b_ack) begin
      if (sbq.size() == 0) begin
        check(b_ack ? "unexpected_b_ack" : "unexpected_a_ack", 32'(1), 32'(0));
      end else begin
        e = sbq.pop_front();
        check("ack_id", 32'(b_ack), 32'(e.id));
        if (!e.we) begin
          check(e.id ? "b_rdata" : "a_rdata", 32'(e.id ? b_rdata : a_rdata), 32'(e.data));
        end
        $display("txn: %s %s addr=%0d rdata=0x%0h cycle=%0d", b_ack ? "B" : "A",
                 e.we ? "write" : "read ", mem_addr, b_ack ? b_rdata : a_rdata, cyc);
      end
    end
  end

  // Drives one command and waits (bounded) for its ack; lat counts cycles from issue to ack
  task automatic do_txn(input bit id, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] din, output int lat);
    int c0;
    bit got;
    c0 = cyc;
    got = 1'b0;
    if (!id) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_din = din;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_din = din;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (id ? b_ack : a_ack) got = 1'b1;
    end
    lat = cyc - c0;
    if (!id) a_req = 1'b0;
    else     b_req = 1'b0;
    if (!got) check(id ? "b_ack_timeout" : "a_ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_ack"},    32'(a_ack),    32'(0));
    check({tag, "_b_ack"},    32'(b_ack),    32'(0));
    check({tag, "_a_rdata"},  32'(a_rdata),  32'(0));
    check({tag, "_b_rdata"},  32'(b_rdata),  32'(0));
    check({tag, "_mem_we"},   32'(mem_we),   32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_mem_din"},  32'(mem_din),  32'(0));
    check({tag, "_busy"},     32'(busy),     32'(0));
  endtask

  int lat, lat_a, lat_b, we0;

  initial begin
    rst = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // A write then A read of addr 3, with latency checks
    push_exp(1'b0, 1'b1, 8'h00);
    do_txn(1'b0, 1'b1, 3'd3, 8'h33, lat);
    check("wr_latency", 32'(lat), 32'(2));
    @(negedge clk);
    push_exp(1'b0, 1'b0, 8'h33);
    do_txn(1'b0, 1'b0, 3'd3, 8'h00, lat);
    check("rd_latency", 32'(lat), 32'(1 + RD_LAT + 1));

    // Reset in ACCESS of a B write (priority is B at this point)
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 3'd0; b_din = 8'h55;
    @(negedge clk);
    check("access_busy", 32'(busy), 32'(1));
    check("access_mem_we", 32'(mem_we), 32'(1));
    rst = 1'b0;
    b_req = 1'b0;
    #1;
    check_zero("rst_access");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous writes to addr 1: priority back at A, so A then B
    push_exp(1'b0, 1'b1, 8'h00);
    push_exp(1'b1, 1'b1, 8'h00);
    fork
      do_txn(1'b0, 1'b1, 3'd1, 8'h11, lat_a);
      do_txn(1'b1, 1'b1, 3'd1, 8'h22, lat_b);
    join
    check("tie_a_latency", 32'(lat_a), 32'(2));
    @(negedge clk);
    push_exp(1'b1, 1'b0, 8'h22);
    do_txn(1'b1, 1'b0, 3'd1, 8'h00, lat);

    // Continuous requests from both: strict alternation, one mem_we per write
    @(negedge clk);
    we0 = we_count;
    for (int k = 0; k < 8; k++) push_exp(k[0], 1'b1, 8'h00);
    fork
      begin
        for (int k = 0; k < 4; k++) do_txn(1'b0, 1'b1, 3'(4 + k), 8'(8'hA0 + k), lat_a);
      end
      begin
        for (int k = 0; k < 4; k++) do_txn(1'b1, 1'b1, 3'(4 + k), 8'(8'hB0 + k), lat_b);
      end
    join
    check("alt_mem_we_count", 32'(we_count - we0), 32'(8));

    // Reset during WAIT of a B read: no ack, rdata stays 0, then reissue
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd1;
    @(negedge clk);
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'(1));
    rst = 1'b0;
    b_req = 1'b0;
    #1;
    check_zero("rst_wait");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("b_rdata_after_rst", 32'(b_rdata), 32'(0));
    push_exp(1'b1, 1'b0, 8'h22);
    do_txn(1'b1, 1'b0, 3'd1, 8'h00, lat);
    check("reissue_rd_latency", 32'(lat), 32'(1 + RD_LAT + 1));

    // B fills memory, A reads it back; B's rdata is untouched by writes
    we0 = we_count;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      push_exp(1'b1, 1'b1, 8'h00);
      do_txn(1'b1, 1'b1, 3'(k), 8'(k * 8'h11), lat);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      push_exp(1'b0, 1'b0, 8'(k * 8'h11));
      do_txn(1'b0, 1'b0, 3'(k), 8'h00, lat);
    end
    check("fill_mem_we_count", 32'(we_count - we0), 32'(8));
    check("b_rdata_held", 32'(b_rdata), 32'(8'h22));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
